dr_counter_ring: RTL and testbench
==================================

Name: dr_counter_ring

Overview:
Parametrised, clocked successor to the dual-rail digit counter ring. It is a WIDTH-bit up/down/loadable counter that presents its value as dual-rail DATA/NULL wavefronts under a return-to-NULL completion handshake. The increment/decrement carry is pipelined in SEG_W-bit segments with data-dependent completion: latency ends at the first segment with no carry. It sits between NCL-style pipeline stages and a clocked control domain.

Parameters:
WIDTH, 32, counter width in bits; must be a multiple of SEG_W.
SEG_W, 4, bits per carry-pipeline segment; NSEG = WIDTH/SEG_W.

Ports:
clk  in  1  single clock, rising edge
init_n  in  1  asynchronous active-low reset
en  in  1  count/load request; sampled only in S_NULL
dir  in  1  1 = increment, 0 = decrement; sampled with en
load  in  1  1 = load load_val instead of counting; sampled with en
load_val  in  WIDTH  load value; sampled with en
cnt_comp  in  1  consumer completion: 1 = DATA accepted, requesting NULL; 0 = NULL accepted, requesting DATA
cnt_dr  out  2*WIDTH  dual-rail value; bit i is {cnt_dr[2i+1]=rail1, cnt_dr[2i]=rail0}
wrap_dr  out  2  dual-rail wrap flag, same encoding
busy  out  1  1 when state != S_NULL

Behaviour:
- Dual-rail encoding: NULL=00, logic0=01, logic1=10; 11 is never driven. All outputs are registered.
- Reset (init_n low, asynchronous): count=0, state=S_NULL, cnt_dr all 0, wrap_dr=00, busy=0. Reset mid-operation aborts any S_CALC/S_DATA immediately; no partial value is retained.
- S_NULL: outputs NULL.
  - If cnt_comp=0 and en=1: capture dir, load and load_val.
  - load=1: count<=load_val; go to S_DATA. DATA is visible 1 cycle after the sampling edge, with wrap=0.
  - load=0: seg_idx<=0; go to S_CALC.
  - cnt_comp=1 or en=0: stay in S_NULL.
- S_CALC: each cycle adds (dir=1) or subtracts (dir=0) the carry/borrow into segment seg_idx; segment 0 uses carry-in 1.
  - If the segment's carry/borrow-out is 0, or seg_idx=NSEG-1: go to S_DATA.
  - Otherwise seg_idx++.
  - Cycles spent = min(j+1, NSEG), where j = number of low segments that are all ones (up) or all zeros (down).
  - cnt_comp is ignored in this state.
- Wrap flag: carry/borrow-out of segment NSEG-1. Up from all-ones gives 0 with wrap=1; down from 0 gives all-ones with wrap=1.
- S_DATA: drive DATA for count and wrap, held stable while cnt_comp=0 or 1. When cnt_comp=1, go to S_NULL; outputs are NULL the next cycle.
- en/dir/load changes outside S_NULL have no effect.

Optional Feature:
DRC_INIT_DATA_EN
- Defined: reset enters S_DATA with count=0, presenting cnt_dr = logic0 on every bit and wrap_dr=01. This is the initial DATA token of a ring.
- Undefined: reset enters S_NULL with NULL outputs, as above.

Decomposition:
- Package dr_counter_pkg: state enum (S_NULL, S_CALC, S_DATA); constants DR_NULL, DR_0, DR_1; function dr_encode(bit) returning 2 bits.
- One sub-module, dr_seg_incdec: SEG_W-bit combinational inc/dec with carry-in, dir, sum and carry-out. Instantiated once and muxed by seg_idx.

Test Plan:
WIDTH=8, SEG_W=4 for all scenarios.
- Reset: hold init_n=0 -> cnt_dr=16'h0000, wrap_dr=00, busy=0. With DRC_INIT_DATA_EN -> cnt_dr=16'h5555, wrap_dr=01.
- Increment from 0x00: en=1, dir=1, cnt_comp=0 -> 1 S_CALC cycle; cnt_dr=16'h5556 two cycles after the sample edge; wrap_dr=01.
- Increment from 0x0F -> 2 S_CALC cycles; value 0x10 (cnt_dr=16'h5655) three cycles after the sample edge.
- Wrap both ways: up from 0xFF -> cnt_dr=16'h5555, wrap_dr=10; down from 0x00 -> cnt_dr=16'hAAAA, wrap_dr=10.
- Load 0xA5 -> cnt_dr=16'h9966 one cycle after the sample edge. Hold cnt_comp=0 for 5 cycles -> DATA stable. Raise cnt_comp -> NULL next cycle. en ignored while cnt_comp=1.
- Assert init_n=0 during S_CALC of 0x0F -> outputs NULL immediately. The first request after release counts from 0x00.

Source files
------------

// File: rtl/dr_counter_pkg.sv
// Shared types and dual-rail encoding helpers for the dual-rail counter ring.
package dr_counter_pkg;

  typedef enum logic [1:0] {
    S_NULL = 2'd0,
    S_CALC = 2'd1,
    S_DATA = 2'd2
  } state_t;

  // Dual-rail codes: {rail1, rail0}. 2'b11 is illegal and never driven.
  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_0    = 2'b01;
  localparam logic [1:0] DR_1    = 2'b10;

  function automatic logic [1:0] dr_encode(input logic b);
    return b ? DR_1 : DR_0;
  endfunction

endpackage

// File: rtl/dr_seg_incdec.sv
// One SEG_W-bit segment of the counter's carry pipeline: adds (dir=1) or
// subtracts (dir=0) the incoming carry/borrow and reports carry/borrow-out.
module dr_seg_incdec #(
  parameter int unsigned SEG_W = 4
) (
  input  logic [SEG_W-1:0] a,
  input  logic             cin,
  input  logic             dir,
  output logic [SEG_W-1:0] sum,
  output logic             cout
);

  // Segment add/subtract with carry/borrow-out.
  always_comb begin
    if (dir) begin
      {cout, sum} = {1'b0, a} + (SEG_W + 1)'(cin);
    end else begin
      sum  = a - SEG_W'(cin);
      cout = cin & (a == '0);
    end
  end

endmodule

// File: rtl/dr_counter_ring.sv
// Dual-rail up/down/loadable counter with a segmented, data-dependent carry
// pipeline and a return-to-NULL completion handshake.
// Optional: define DRC_INIT_DATA_EN to make reset present an initial DATA
// token (count=0, wrap=0) instead of NULL.
module dr_counter_ring
  import dr_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG_W = 4
) (
  input  logic               clk,
  input  logic               init_n,
  input  logic               en,
  input  logic               dir,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic               cnt_comp,
  output logic [2*WIDTH-1:0] cnt_dr,
  output logic [1:0]         wrap_dr,
  output logic               busy
);

  localparam int unsigned NSEG  = WIDTH / SEG_W;
  localparam int unsigned IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [IDX_W-1:0] LAST_SEG = IDX_W'(NSEG - 1);

`ifdef DRC_INIT_DATA_EN
  localparam logic [2*WIDTH-1:0] INIT_DR = {WIDTH{DR_0}};
`endif

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   count, count_nxt;
  logic [IDX_W-1:0]   seg_idx, seg_idx_nxt;
  logic               dir_q, dir_nxt;
  logic               wrap, wrap_nxt;

  logic [SEG_W-1:0]   seg_a;
  logic [SEG_W-1:0]   seg_sum;
  logic               seg_cout;
  logic [2*WIDTH-1:0] data_dr;

  // Select the segment currently being processed by the carry pipeline.
  always_comb begin
    seg_a = '0;
    for (int unsigned s = 0; s < NSEG; s++) begin
      if (32'(seg_idx) == s) begin
        seg_a = count[s*SEG_W +: SEG_W];
      end
    end
  end

  // Carry-in is tied to 1: a later segment is only visited after the previous
  // one produced a carry/borrow, and segment 0 always starts with +/-1.
  dr_seg_incdec #(
    .SEG_W (SEG_W)
  ) u_seg (
    .a    (seg_a),
    .cin  (1'b1),
    .dir  (dir_q),
    .sum  (seg_sum),
    .cout (seg_cout)
  );

  // Next-state and next-datapath logic for the handshake/carry FSM.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    seg_idx_nxt = seg_idx;
    dir_nxt     = dir_q;
    wrap_nxt    = wrap;
    case (state)
      S_NULL: begin
        if (!cnt_comp && en) begin
          dir_nxt = dir;
          if (load) begin
            count_nxt = load_val;
            wrap_nxt  = 1'b0;
            state_nxt = S_DATA;
          end else begin
            seg_idx_nxt = '0;
            state_nxt   = S_CALC;
          end
        end
      end
      S_CALC: begin
        for (int unsigned s = 0; s < NSEG; s++) begin
          if (32'(seg_idx) == s) begin
            count_nxt[s*SEG_W +: SEG_W] = seg_sum;
          end
        end
        // A carry-out can only survive to here from the top segment, so it
        // is directly the wrap flag.
        if (!seg_cout || (seg_idx == LAST_SEG)) begin
          wrap_nxt  = seg_cout;
          state_nxt = S_DATA;
        end else begin
          seg_idx_nxt = seg_idx + IDX_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_comp) begin
          state_nxt = S_NULL;
        end
      end
      default: state_nxt = S_NULL;
    endcase
  end

  // Dual-rail image of the held count.
  always_comb begin
    data_dr = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      data_dr[2*i +: 2] = dr_encode(count[i]);
    end
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
`ifdef DRC_INIT_DATA_EN
      state   <= S_DATA;
`else
      state   <= S_NULL;
`endif
      count   <= '0;
      seg_idx <= '0;
      dir_q   <= 1'b1;
      wrap    <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      seg_idx <= seg_idx_nxt;
      dir_q   <= dir_nxt;
      wrap    <= wrap_nxt;
    end
  end

  // Registered outputs: DATA wavefront while holding a token, NULL otherwise.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
`ifdef DRC_INIT_DATA_EN
      cnt_dr  <= INIT_DR;
      wrap_dr <= DR_0;
      busy    <= 1'b1;
`else
      cnt_dr  <= '0;
      wrap_dr <= DR_NULL;
      busy    <= 1'b0;
`endif
    end else begin
      cnt_dr  <= (state == S_DATA) ? data_dr : '0;
      wrap_dr <= (state == S_DATA) ? dr_encode(wrap) : DR_NULL;
      busy    <= (state_nxt != S_NULL);
    end
  end

endmodule

// File: tb/tb_dr_counter_ring.sv
// Self-checking bench for dr_counter_ring (WIDTH=8, SEG_W=4): directed
// literal scenarios plus randomized traffic against a behavioural model.
module tb_dr_counter_ring;

  localparam int unsigned W    = 8;
  localparam int unsigned SW   = 4;
  localparam int unsigned NSEG = W / SW;

`ifdef DRC_INIT_DATA_EN
  localparam logic [15:0] RST_DR   = 16'h5555;
  localparam logic [1:0]  RST_WRAP = 2'b01;
  localparam logic        RST_BUSY = 1'b1;
`else
  localparam logic [15:0] RST_DR   = 16'h0000;
  localparam logic [1:0]  RST_WRAP = 2'b00;
  localparam logic        RST_BUSY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        init_n = 1'b0;
  logic        en = 1'b0;
  logic        dir = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  load_val = 8'h00;
  logic        cnt_comp = 1'b0;
  logic [15:0] cnt_dr;
  logic [1:0]  wrap_dr;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dr_counter_ring #(
    .WIDTH (W),
    .SEG_W (SW)
  ) dut (
    .clk      (clk),
    .init_n   (init_n),
    .en       (en),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .cnt_comp (cnt_comp),
    .cnt_dr   (cnt_dr),
    .wrap_dr  (wrap_dr),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] enc8(input logic [7:0] v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  // Cycles in the carry pipeline: one per low segment that propagates, plus
  // the one that stops it, capped at the number of segments.
  function automatic int calc_cycles(input logic [7:0] v, input logic up);
    int  j;
    bit  run;
    logic [3:0] seg;
    j   = 0;
    run = 1'b1;
    for (int s = 0; s < int'(NSEG); s++) begin
      seg = 4'((v >> (4 * s)) & 8'h0F);
      if (run && (up ? (seg == 4'hF) : (seg == 4'h0))) j++;
      else run = 1'b0;
    end
    return (j + 1 < int'(NSEG)) ? j + 1 : int'(NSEG);
  endfunction

  // Behavioural model: phase 0 = waiting for request, 1 = computing,
  // 2 = holding the token. Outputs show the token the cycle after holding.
  int          m_phase;
  int          m_old;
  int          m_wait;
  logic [7:0]  m_count;
  logic        m_wrap;
  logic [15:0] exp_dr   = RST_DR;
  logic [1:0]  exp_wrap = RST_WRAP;
  logic        exp_busy = RST_BUSY;

  always @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      m_count  = 8'h00;
      m_wrap   = 1'b0;
      m_wait   = 0;
`ifdef DRC_INIT_DATA_EN
      m_phase  = 2;
`else
      m_phase  = 0;
`endif
      exp_dr   = RST_DR;
      exp_wrap = RST_WRAP;
      exp_busy = RST_BUSY;
    end else begin
      m_old = m_phase;
      case (m_phase)
        0: if (en && !cnt_comp) begin
          if (load) begin
            m_count = load_val;
            m_wrap  = 1'b0;
            m_phase = 2;
          end else begin
            m_wait  = calc_cycles(m_count, dir);
            m_wrap  = dir ? (m_count == 8'hFF) : (m_count == 8'h00);
            m_count = dir ? 8'(m_count + 8'd1) : 8'(m_count - 8'd1);
            m_phase = 1;
          end
        end
        1: begin
          m_wait--;
          if (m_wait == 0) m_phase = 2;
        end
        default: if (cnt_comp) m_phase = 0;
      endcase
      exp_dr   = (m_old == 2) ? enc8(m_count) : 16'h0000;
      exp_wrap = (m_old == 2) ? (m_wrap ? 2'b10 : 2'b01) : 2'b00;
      exp_busy = (m_phase != 0);
    end
  end

  // Continuous comparison against the model on the inactive clock edge.
  always @(negedge clk) begin
    check("model_cnt_dr", 32'(cnt_dr), 32'(exp_dr));
    check("model_wrap_dr", 32'(wrap_dr), 32'(exp_wrap));
    check("model_busy", 32'(busy), 32'(exp_busy));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic ld, input logic up, input logic [7:0] val, input int lat,
                         input logic [15:0] want, input logic [1:0] want_wrap);
    en = 1'b1; load = ld; dir = up; load_val = val;
    tick();
    en = 1'b0; load = 1'b0;
    check("busy_after_sample", 32'(busy), 32'd1);
    for (int k = 1; k < lat; k++) begin
      tick();
      check("null_while_calc", 32'(cnt_dr), 32'h0);
    end
    tick();
    check("data_value", 32'(cnt_dr), 32'(want));
    check("data_wrap", 32'(wrap_dr), 32'(want_wrap));
  endtask

  // Consumer accepts DATA; en is held high meanwhile and must be ignored.
  task automatic release_tok();
    cnt_comp = 1'b1; en = 1'b1;
    tick();
    check("busy_drop", 32'(busy), 32'd0);
    tick();
    check("null_after_comp", 32'(cnt_dr), 32'h0);
    check("null_wrap_after_comp", 32'(wrap_dr), 32'h0);
    tick();
    check("en_ignored_comp", 32'(busy), 32'd0);
    en = 1'b0; cnt_comp = 1'b0;
  endtask

  task automatic post_reset();
`ifdef DRC_INIT_DATA_EN
    release_tok();
`endif
  endtask

  initial begin
    init_n = 1'b0;
    repeat (3) tick();
    check("reset_cnt_dr", 32'(cnt_dr), 32'(RST_DR));
    check("reset_wrap_dr", 32'(wrap_dr), 32'(RST_WRAP));
    check("reset_busy", 32'(busy), 32'(RST_BUSY));
    init_n = 1'b1;
    tick();
    post_reset();

    request(1'b0, 1'b1, 8'h00, 2, 16'h5556, 2'b01); release_tok();
    request(1'b1, 1'b0, 8'h0F, 1, 16'h55AA, 2'b01); release_tok();
    request(1'b0, 1'b1, 8'h00, 3, 16'h5655, 2'b01); release_tok();
    request(1'b0, 1'b0, 8'h00, 3, 16'h55AA, 2'b01); release_tok();
    request(1'b1, 1'b0, 8'hFF, 1, 16'hAAAA, 2'b01); release_tok();
    request(1'b0, 1'b1, 8'h00, 3, 16'h5555, 2'b10); release_tok();
    request(1'b0, 1'b0, 8'h00, 3, 16'hAAAA, 2'b10); release_tok();
    request(1'b1, 1'b0, 8'hA5, 1, 16'h9966, 2'b01);
    repeat (5) begin
      tick();
      check("hold_stable", 32'(cnt_dr), 32'h9966);
    end
    release_tok();

    // Reset in the middle of a two-segment carry.
    request(1'b1, 1'b0, 8'h0F, 1, 16'h55AA, 2'b01); release_tok();
    en = 1'b1; load = 1'b0; dir = 1'b1;
    tick();
    en = 1'b0;
    tick();
    check("busy_mid_calc", 32'(busy), 32'd1);
    init_n = 1'b0;
    #1;
    check("abort_cnt_dr", 32'(cnt_dr), 32'(RST_DR));
    check("abort_busy", 32'(busy), 32'(RST_BUSY));
    tick(); tick();
    init_n = 1'b1;
    tick();
    post_reset();
    request(1'b0, 1'b1, 8'h00, 2, 16'h5556, 2'b01); release_tok();

    // Randomized traffic checked by the model.
    for (int c = 0; c < 800; c++) begin
      en       = 1'($urandom_range(0, 1));
      load     = ($urandom_range(0, 3) == 0);
      dir      = 1'($urandom_range(0, 1));
      cnt_comp = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 4))
        0: load_val = 8'h00;
        1: load_val = 8'hFF;
        2: load_val = 8'h0F;
        3: load_val = 8'hF0;
        default: load_val = 8'($urandom);
      endcase
      tick();
    end
    en = 1'b0; cnt_comp = 1'b0;
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
